// File: rtl/pid_ctrl_gen.sv
// Decimated PID controller for the e-bike motor drive: signed error in, clipped unsigned drive out.
// drv_mag/sat are registered (1 clk after inputs); integrator and history advance only on dec_tick.
module pid_ctrl_gen #(
  parameter int ERR_W      = 13,
  parameter int OUT_W      = 12,
  parameter int INT_W      = 18,
  parameter int D_DEPTH    = 3,
  parameter int D_SAT_W    = 9,
  parameter int KD_SHIFT   = 1,
  parameter int DEC_W      = 20,
  parameter int FAST_SIM   = 0,
  parameter int FAST_DEC_W = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ERR_W-1:0] error,
  input  logic             not_pedaling,
  input  logic             en,
  input  logic             int_clr,
  output logic [OUT_W-1:0] drv_mag,
  output logic             sat,
  output logic             dec_tick
);

  localparam int N  = (FAST_SIM != 0) ? FAST_DEC_W : DEC_W;
  localparam int S0 = (ERR_W > OUT_W + 1) ? ERR_W : OUT_W + 1;
  localparam int S  = ((S0 > D_SAT_W + KD_SHIFT) ? S0 : D_SAT_W + KD_SHIFT) + 2;

  logic [DEC_W-1:0] r_cnt;
  logic [INT_W-1:0] r_integ;
  logic [ERR_W-1:0] r_hist [D_DEPTH];
  logic [OUT_W-1:0] r_drv_mag;
  logic             r_sat;

  logic             w_tick;
  logic [INT_W:0]   w_isum;
  logic [INT_W-1:0] w_integ_nxt;
  logic             w_hold;
  logic [ERR_W-1:0] w_prev;
  logic [ERR_W:0]   w_diff;
  logic             w_dfit;
  logic [D_SAT_W-1:0] w_dsat;
  logic [S-1:0]     w_p;
  logic [S-1:0]     w_i;
  logic [S-1:0]     w_d;
  logic [S-1:0]     w_sum;
  logic             w_neg;
  logic             w_big;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= r_cnt + {{(DEC_W-1){1'b0}}, 1'b1};
  end

  assign w_tick   = &r_cnt[N-1:0];
  assign dec_tick = w_tick;

  // r_integ never exceeds 2^(INT_W-1)-1, so bit INT_W-1 of the sum flags overflow
  assign w_isum = {1'b0, r_integ} + {{(INT_W+1-ERR_W){error[ERR_W-1]}}, error};

  always_comb begin
    w_integ_nxt = w_isum[INT_W-1:0];
    if (w_isum[INT_W])        w_integ_nxt = '0;
    else if (w_isum[INT_W-1]) w_integ_nxt = {1'b0, {(INT_W-1){1'b1}}};
  end

  // Stop winding up while the output is already pinned high and error still pushes up
  assign w_hold = r_sat && (&r_drv_mag) && !error[ERR_W-1] && (|error);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_integ <= '0;
    else if (int_clr || not_pedaling)   r_integ <= '0;
    else if (en && w_tick && !w_hold)   r_integ <= w_integ_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < D_DEPTH; k++) r_hist[k] <= '0;
    end else if (en && w_tick) begin
      r_hist[0] <= error;
      for (int k = 1; k < D_DEPTH; k++) r_hist[k] <= r_hist[k-1];
    end
  end

  assign w_prev = r_hist[D_DEPTH-1];
  assign w_diff = {error[ERR_W-1], error} - {w_prev[ERR_W-1], w_prev};

  // In range when all bits above the D_SAT_W sign bit match it
  assign w_dfit = (&w_diff[ERR_W:D_SAT_W-1]) | ~(|w_diff[ERR_W:D_SAT_W-1]);
  assign w_dsat = w_dfit ? w_diff[D_SAT_W-1:0] :
                  (w_diff[ERR_W] ? {1'b1, {(D_SAT_W-1){1'b0}}} : {1'b0, {(D_SAT_W-1){1'b1}}});

  assign w_p   = {{(S-ERR_W){error[ERR_W-1]}}, error};
  assign w_i   = {{(S-OUT_W){1'b0}}, r_integ[INT_W-2 -: OUT_W]};
  assign w_d   = {{(S-D_SAT_W){w_dsat[D_SAT_W-1]}}, w_dsat} << KD_SHIFT;
  assign w_sum = w_p + w_i + w_d;
  assign w_neg = w_sum[S-1];
  assign w_big = !w_neg && (|w_sum[S-2:OUT_W]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drv_mag <= '0;
      r_sat     <= 1'b0;
    end else if (en) begin
      r_drv_mag <= w_neg ? '0 : (w_big ? {OUT_W{1'b1}} : w_sum[OUT_W-1:0]);
      r_sat     <= w_neg | w_big;
    end
  end

  assign drv_mag = r_drv_mag;
  assign sat     = r_sat;

endmodule

// File: tb/tb_pid_ctrl_gen.sv
// Bench for pid_ctrl_gen: integer reference model feeds a scoreboard queue, a monitor checks every cycle.
// Uses a 4-bit fast decimator so each tick period is 16 clocks.
module tb_pid_ctrl_gen;

  localparam int EW   = 13;
  localparam int OW   = 12;
  localparam int IW   = 18;
  localparam int DD   = 3;
  localparam int KS   = 1;
  localparam int N    = 4;
  localparam int OMAX = (1 << OW) - 1;
  localparam int IMAX = (1 << (IW - 1)) - 1;
  localparam int DMAX = 255;
  localparam int DMIN = -256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [EW-1:0] error = '0;
  logic          not_pedaling = 1'b0;
  logic          en = 1'b1;
  logic          int_clr = 1'b0;
  logic [OW-1:0] drv_mag;
  logic          sat;
  logic          dec_tick;

  pid_ctrl_gen #(.FAST_SIM(1), .FAST_DEC_W(N)) dut (
    .clk(clk), .rst_n(rst_n), .error(error), .not_pedaling(not_pedaling),
    .en(en), .int_clr(int_clr), .drv_mag(drv_mag), .sat(sat), .dec_tick(dec_tick)
  );

  always #5 clk = ~clk;

  typedef struct { int drv; int sat; int tick; } exp_t;
  exp_t q[$];

  int total = 0;
  int bad   = 0;

  int m_cnt, m_integ, m_drv, m_sat;
  int m_hist [DD];

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_integ = 0; m_drv = 0; m_sat = 0;
    for (int k = 0; k < DD; k++) m_hist[k] = 0;
  endtask

  // Drive one cycle of inputs at a negedge, predict the state after the next posedge, then wait a cycle.
  task automatic step(input int e, input bit np, input bit cl, input bit en_i);
    int p, it, d, s, t;
    bit tk;
    exp_t x;
    error = e[EW-1:0]; not_pedaling = np; int_clr = cl; en = en_i;
    p  = e;
    it = m_integ / (1 << (IW - 1 - OW));
    d  = e - m_hist[DD-1];
    if (d > DMAX) d = DMAX;
    if (d < DMIN) d = DMIN;
    d  = d * (1 << KS);
    s  = p + it + d;
    tk = (m_cnt == (1 << N) - 1);
    if (np || cl) m_integ = 0;
    else if (en_i && tk && !(m_sat == 1 && m_drv == OMAX && e > 0)) begin
      t = m_integ + e;
      m_integ = (t < 0) ? 0 : (t > IMAX) ? IMAX : t;
    end
    if (en_i && tk) begin
      for (int k = DD - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = e;
    end
    if (en_i) begin
      m_drv = (s < 0) ? 0 : (s > OMAX) ? OMAX : s;
      m_sat = (s < 0 || s > OMAX) ? 1 : 0;
    end
    m_cnt = (m_cnt + 1) % (1 << N);
    x.drv = m_drv; x.sat = m_sat; x.tick = (m_cnt == (1 << N) - 1) ? 1 : 0;
    q.push_back(x);
    @(negedge clk);
  endtask

  task automatic run(input int n, input int e);
    for (int k = 0; k < n; k++) step(e, 1'b0, 1'b0, 1'b1);
  endtask

  // Called at a negedge; reset must clear the outputs without waiting for a clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_drv", drv_mag, 0);
    chk("rst_sat", sat, 0);
    chk("rst_tick", dec_tick, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("mon_drv", drv_mag, x.drv);
        chk("mon_sat", sat, x.sat);
        chk("mon_tick", dec_tick, x.tick);
      end
    end
  end

  initial begin
    int first, hold_drv, hold_sat, r, e;
    model_reset();
    repeat (3) @(negedge clk);
    do_reset();

    // First tick: the counter reaches all-ones after 2^N - 1 edges (the 2^N-th cycle)
    first = -1;
    for (int k = 1; k <= 40; k++) begin
      step(0, 1'b0, 1'b0, 1'b1);
      if (dec_tick && first < 0) first = k;
    end
    chk("first_tick", first, (1 << N) - 1);

    do_reset();
    step(100, 1'b0, 1'b0, 1'b1);
    chk("p_plus_d_300", drv_mag, 300);
    run(48, 100);
    chk("three_ticks_109", drv_mag, 109);
    run(464, 100);
    chk("32_ticks_200", drv_mag, 200);

    do_reset();
    run(20, 0);
    step(1000, 1'b0, 1'b0, 1'b1);
    chk("dsat_1510", drv_mag, 1510);
    chk("dsat_nosat", sat, 0);

    do_reset();
    run(40, 4095);
    chk("pos_clip", drv_mag, OMAX);
    chk("pos_sat", sat, 1);
    run(64, 0);
    chk("windup_frozen", drv_mag, 0);
    step(-4096, 1'b0, 1'b0, 1'b1);
    chk("neg_clip", drv_mag, 0);
    chk("neg_sat", sat, 1);

    do_reset();
    run(80, 500);
    run(64, 0);
    chk("integ_i78", drv_mag, 78);
    step(0, 1'b1, 1'b0, 1'b1);
    step(0, 1'b0, 1'b0, 1'b1);
    chk("np_clear", drv_mag, 0);
    run(80, 500);
    run(64, 0);
    step(0, 1'b0, 1'b1, 1'b1);
    step(0, 1'b0, 1'b0, 1'b1);
    chk("clr_clear", drv_mag, 0);

    run(10, 700);
    hold_drv = m_drv; hold_sat = m_sat;
    for (int k = 0; k < 48; k++) step(int'($urandom_range(0, 8191)) - 4096, 1'b0, 1'b0, 1'b0);
    chk("freeze_drv", drv_mag, hold_drv);
    chk("freeze_sat", sat, hold_sat);
    step(1200, 1'b0, 1'b0, 1'b1);
    do_reset();

    e = 0;
    for (int k = 1; k <= 2000; k++) begin
      r = int'($urandom_range(0, 3));
      case (r)
        0: e = int'($urandom_range(0, 400)) - 200;
        1: e = int'($urandom_range(0, 8191)) - 4096;
        2: e = e;
        default: e = int'($urandom_range(2000, 4095));
      endcase
      step(e, ($urandom_range(0, 24) == 0), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 9) != 0));
      if (k % 700 == 0) do_reset();
    end

    repeat (2) @(posedge clk);
    #2;
    if (q.size() != 0) chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
